// File: rtl/instr_encoder.sv
// MIPS instruction encoder: turns op-select plus field requests into 32-bit
// instruction words, queued in a small FIFO and drained over valid/ready.
module instr_encoder #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNTW  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [3:0]                   op_sel,
  input  logic [4:0]                   rs,
  input  logic [4:0]                   rt,
  input  logic [4:0]                   rd,
  input  logic [15:0]                  imm,
  input  logic [25:0]                  target,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  instr,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         err,
  output logic [CNTW-1:0]              illegal_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic [31:0]   enc_word_c;
  logic          legal_c;
  logic          accept_c;
  logic          push_c;
  logic          pop_c;
  logic [LW-1:0] level_nxt_c;

  // Field assembly; unused fields stay zero.
  always_comb begin
    enc_word_c = 32'h0;
    legal_c    = 1'b1;
    case (op_sel)
      4'd0:    enc_word_c = 32'h0;
      4'd1:    enc_word_c = {6'b100011, rs, rt, imm};
      4'd2:    enc_word_c = {6'b101011, rs, rt, imm};
      4'd3:    enc_word_c = {6'b000010, target};
      4'd4:    enc_word_c = {6'b000000, rs, 15'b0, 6'b001000};
      4'd5:    enc_word_c = {6'b000011, target};
      4'd6:    enc_word_c = {6'b000101, rs, rt, imm};
      4'd7:    enc_word_c = {6'b001110, rs, rt, imm};
      4'd8:    enc_word_c = {6'b000000, rs, rt, rd, 5'b0, 6'b100000};
      4'd9:    enc_word_c = {6'b000000, rs, rt, rd, 5'b0, 6'b100010};
      4'd10:   enc_word_c = {6'b000000, rs, rt, rd, 5'b0, 6'b101010};
      default: legal_c    = 1'b0;
    endcase
  end

  // Handshake decode and next occupancy.
  always_comb begin
    accept_c    = in_valid & in_ready;
    push_c      = accept_c & legal_c;
    pop_c       = out_valid & out_ready;
    level_nxt_c = level;
    case ({push_c, pop_c})
      2'b10:   level_nxt_c = level + LW'(1);
      2'b01:   level_nxt_c = level - LW'(1);
      default: level_nxt_c = level;
    endcase
  end

  // Storage is intentionally not reset; pointers and flags gate its visibility.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= enc_word_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      err         <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      level     <= level_nxt_c;
      in_ready  <= (level_nxt_c != LW'(DEPTH));
      out_valid <= (level_nxt_c != '0);
      err       <= accept_c & ~legal_c;
      if (accept_c && !legal_c && !(&illegal_cnt)) begin
        illegal_cnt <= illegal_cnt + CNTW'(1);
      end
    end
  end

  assign instr = out_valid ? mem[rd_ptr] : 32'h0;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder against a queue-based model.
module tb_instr_encoder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNTW  = 8;
  localparam int unsigned LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    op_sel;
  logic [4:0]    rs, rt, rd;
  logic [15:0]   imm;
  logic [25:0]   target;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   instr;
  logic [LW-1:0] level;
  logic          err;
  logic [CNTW-1:0] illegal_cnt;

  int tests = 0;
  int fails = 0;

  logic [31:0] mq[$];
  logic        m_err = 1'b0;
  int          m_cnt = 0;

  instr_encoder #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
    .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
    .level(level), .err(err), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  // Reference encoding from opcode/funct tables and instruction format.
  function automatic logic [31:0] ref_enc(input int op, input int a_rs, input int a_rt,
                                          input int a_rd, input int a_imm, input int a_tgt);
    int opc [11] = '{0, 35, 43, 2, 0, 3, 5, 14, 0, 0, 0};
    int fn  [11] = '{0, 0, 0, 0, 8, 0, 0, 0, 32, 34, 42};
    longint w;
    w = 0;
    if (op == 1 || op == 2 || op == 6 || op == 7)
      w = longint'(opc[op]) * 67108864 + a_rs * 2097152 + a_rt * 65536 + a_imm;
    else if (op == 3 || op == 5)
      w = longint'(opc[op]) * 67108864 + a_tgt;
    else if (op == 4)
      w = a_rs * 2097152 + fn[op];
    else if (op >= 8 && op <= 10)
      w = a_rs * 2097152 + a_rt * 65536 + a_rd * 2048 + fn[op];
    return 32'(w);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int op, input int a_rs, input int a_rt, input int a_rd,
                         input int a_imm, input int a_tgt);
    op_sel = 4'(op); rs = 5'(a_rs); rt = 5'(a_rt); rd = 5'(a_rd);
    imm = 16'(a_imm); target = 26'(a_tgt);
  endtask

  task automatic rand_req(input bit allow_illegal);
    set_req(allow_illegal ? int'($urandom_range(15)) : int'($urandom_range(10)),
            int'($urandom_range(31)), int'($urandom_range(31)), int'($urandom_range(31)),
            int'($urandom_range(65535)), int'($urandom & 32'h03FF_FFFF));
  endtask

  // One clock: advance the model from the driven inputs, then compare every output.
  task automatic tick();
    bit acc, pop, legal;
    logic [31:0] w;
    acc   = in_valid && (mq.size() < DEPTH);
    pop   = out_ready && (mq.size() > 0);
    legal = (op_sel <= 4'd10);
    w     = ref_enc(int'(op_sel), int'(rs), int'(rt), int'(rd), int'(imm), int'(target));
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      m_err = 1'b0;
      m_cnt = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc && legal) mq.push_back(w);
      m_err = acc && !legal;
      if (acc && !legal && m_cnt < 255) m_cnt++;
    end
    #1;
    check("level", 32'(level), 32'(mq.size()));
    check("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
    check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check("instr", instr, (mq.size() != 0) ? mq[0] : 32'h0);
    check("err", 32'(err), 32'(m_err));
    check("illegal_cnt", 32'(illegal_cnt), 32'(m_cnt));
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] seq [4] = '{32'h00430820, 32'h03E00008, 32'h0C000010, 32'h3885FFFF};
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_req(0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst_n = 1'b1;
    check("rst_level", 32'(level), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);

    // LW single push
    set_req(1, 2, 3, 0, 16'h0010, 0); in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    check("lw_instr", instr, 32'h8C430010);
    check("lw_level", 32'(level), 32'h1);
    drain();

    // Ordered push then drain
    in_valid = 1'b1;
    set_req(8, 2, 3, 1, 0, 0);          tick();
    set_req(4, 31, 0, 0, 0, 0);         tick();
    set_req(5, 0, 0, 0, 0, 26'h10);     tick();
    set_req(7, 4, 5, 0, 16'hFFFF, 0);   tick();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("seq_instr", instr, seq[i]);
      tick();
    end
    check("seq_level_empty", 32'(level), 32'h0);
    out_ready = 1'b0;

    // Fill, then a blocked 5th request alongside one pop
    set_req(6, 1, 2, 0, 16'hFFFE, 0); in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) tick();
    check("full_in_ready", 32'(in_ready), 32'h0);
    check("full_head", instr, 32'h1422FFFE);
    set_req(1, 7, 7, 0, 16'h1234, 0); out_ready = 1'b1;
    tick();
    check("full_pop_level", 32'(level), 32'h3);
    check("full_pop_ready", 32'(in_ready), 32'h1);
    drain();

    // Steady state at level 2 with concurrent push/pop
    in_valid = 1'b1;
    rand_req(1'b0); tick();
    rand_req(1'b0); tick();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand_req(1'b0); tick();
    end
    check("pp_level", 32'(level), 32'h2);
    drain();

    // Illegal requests and counter saturation
    set_req(12, 1, 1, 1, 1, 1); in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    check("ill_err", 32'(err), 32'h1);
    check("ill_level", 32'(level), 32'h0);
    check("ill_cnt", 32'(illegal_cnt), 32'h1);
    tick();
    check("ill_err_drop", 32'(err), 32'h0);
    in_valid = 1'b1;
    for (int i = 0; i < 299; i++) tick();
    in_valid = 1'b0; tick();
    check("ill_sat", 32'(illegal_cnt), 32'hFF);

    // Reset with entries queued
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_req(1'b0); tick();
    end
    in_valid = 1'b0; rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    check("rst2_out_valid", 32'(out_valid), 32'h0);
    check("rst2_level", 32'(level), 32'h0);
    check("rst2_instr", instr, 32'h0);
    check("rst2_err", 32'(err), 32'h0);
    check("rst2_cnt", 32'(illegal_cnt), 32'h0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      rand_req(1'b1);
      tick();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
